// File: rtl/ariane_exit_reporter.sv
// End-of-test reporter: captures the first ECALL's counters, divides out milli-IPC,
// then streams a fixed 26-byte packet to the host over a byte valid/ready channel.
module ariane_exit_reporter #(
   parameter logic [7:0] HEADER = 8'hFE,
   parameter int         SCALE  = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ex_i,
   input  logic [63:0] cause_i,
   input  logic [63:0] cycle_i,
   input  logic [63:0] instret_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic        done_o
);

   localparam int             PW      = 64 + $clog2(SCALE);
   localparam int             NBYTES  = 26;
   localparam logic [PW-1:0]  SCALE_W = PW'(SCALE);
   localparam logic [6:0]     DIV_END = 7'(PW);
   localparam logic [4:0]     B_LAST  = 5'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, DIV, SEND, DONE} state_t;

   state_t            state_q, state_d;
   logic [63:0]       c_q, i_q;
   logic [7:0]        k_q;
   logic [PW-1:0]     dq_q;
   logic [63:0]       rem_q;
   logic [6:0]        cnt_q;
   logic [4:0]        b_q;
   logic              busy_q;

   logic              is_ecall;
   logic [PW-1:0]     prod;
   logic [64:0]       rem_sh;
   logic              fits;
   logic [63:0]       rem_sub;
   logic [63:0]       mipc;
   logic [8*NBYTES-1:0] pkt;
   logic [7:0]        tx_byte;

   assign is_ecall = (cause_i == 64'd8) || (cause_i == 64'd9) || (cause_i == 64'hb);
   assign prod     = {{(PW-64){1'b0}}, i_q} * SCALE_W;

   // When the divisor fits, the true remainder is below C, so a 64-bit modular subtract is exact.
   assign rem_sh   = {rem_q, dq_q[PW-1]};
   assign fits     = rem_sh >= {1'b0, c_q};
   assign rem_sub  = rem_sh[63:0] - c_q;

   assign mipc     = (c_q == 64'd0) ? '1 : dq_q[63:0];
   assign pkt      = {mipc, i_q, c_q, k_q, HEADER};

   always_comb begin
      tx_byte = 8'h00;
      for (int j = 0; j < NBYTES; j++) begin
         if (b_q == 5'(j)) tx_byte = pkt[j*8 +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (ex_i && is_ecall)             state_d = DIV;
         DIV:  if (cnt_q == DIV_END)             state_d = SEND;
         SEND: if (tx_ready_i && b_q == B_LAST)  state_d = DONE;
         DONE: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Counter value 0 loads the dividend; values 1..PW each produce one quotient bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         c_q     <= '0;
         i_q     <= '0;
         k_q     <= '0;
         dq_q    <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == DIV) || (state_d == SEND);
         case (state_q)
            IDLE: begin
               if (ex_i && is_ecall) begin
                  c_q   <= cycle_i;
                  i_q   <= instret_i;
                  k_q   <= cause_i[7:0];
                  cnt_q <= '0;
               end
            end
            DIV: begin
               cnt_q <= cnt_q + 7'd1;
               b_q   <= '0;
               if (cnt_q == 7'd0) begin
                  dq_q  <= prod;
                  rem_q <= '0;
               end else begin
                  dq_q  <= {dq_q[PW-2:0], fits};
                  rem_q <= fits ? rem_sub : rem_sh[63:0];
               end
            end
            SEND: begin
               if (tx_ready_i) b_q <= b_q + 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign tx_valid_o = (state_q == SEND);
   assign tx_data_o  = (state_q == SEND) ? tx_byte : 8'h00;
   assign busy_o     = busy_q;
   assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_ariane_exit_reporter.sv
// Bench for ariane_exit_reporter: directed and random packets compared against
// a byte-list model built with wide arithmetic straight from the packet layout.
module tb_ariane_exit_reporter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ex_i;
   logic [63:0] cause_i;
   logic [63:0] cycle_i;
   logic [63:0] instret_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        busy_o;
   logic        done_o;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  exp_q [26];

   ariane_exit_reporter dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ex_i       (ex_i),
      .cause_i    (cause_i),
      .cycle_i    (cycle_i),
      .instret_i  (instret_i),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected packet: header, cause byte, then C, I and milli-IPC little-endian.
   task automatic buildPacket(input logic [63:0] c, input logic [63:0] i, input logic [63:0] cause);
      logic [127:0] n;
      logic [127:0] q;
      logic [63:0]  m;
      n = {64'd0, i} * 128'd1000;
      if (c == 64'd0) m = '1;
      else begin
         q = n / {64'd0, c};
         m = q[63:0];
      end
      exp_q[0] = 8'hFE;
      exp_q[1] = cause[7:0];
      for (int k = 0; k < 8; k++) begin
         exp_q[2+k]  = c[8*k +: 8];
         exp_q[10+k] = i[8*k +: 8];
         exp_q[18+k] = m[8*k +: 8];
      end
   endtask

   task automatic doReset();
      @(negedge clk_i);
      rst_i = 1'b1; ex_i = 1'b0; tx_ready_i = 1'b0;
      #1;
      checkOutput("rst_valid", 64'(tx_valid_o), 64'd0);
      checkOutput("rst_data", 64'(tx_data_o), 64'd0);
      @(negedge clk_i);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
      checkOutput("rst_done", 64'(done_o), 64'd0);
      rst_i = 1'b0;
   endtask

   // Fires an ECALL, checks latency, then collects stop_at bytes with optional random stalls.
   task automatic applyStimulus(input logic [63:0] c, input logic [63:0] i, input logic [63:0] cause,
                                input bit rnd, input int stop_at);
      int m;
      int idx;
      int cyc;
      bit r;
      buildPacket(c, i, cause);
      ex_i = 1'b1; cause_i = cause; cycle_i = c; instret_i = i;
      @(negedge clk_i);
      ex_i = 1'b0;
      checkOutput("busy_div", 64'(busy_o), 64'd1);
      checkOutput("valid_div", 64'(tx_valid_o), 64'd0);
      m = 0;
      while (!tx_valid_o && m < 300) begin
         if (m == 10) begin
            ex_i = 1'b1; cause_i = 64'd8; cycle_i = ~c; instret_i = ~i;
         end else ex_i = 1'b0;
         @(negedge clk_i);
         m++;
      end
      ex_i = 1'b0;
      checkOutput("latency", 64'(m), 64'd75);
      idx = 0;
      cyc = 0;
      while (idx < stop_at && cyc < 2000) begin
         checkOutput($sformatf("valid_b%0d", idx), 64'(tx_valid_o), 64'd1);
         checkOutput($sformatf("byte%0d", idx), 64'(tx_data_o), 64'(exp_q[idx]));
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (idx == 5) begin
            ex_i = 1'b1; cause_i = 64'd9; cycle_i = 64'h1234; instret_i = 64'h5678;
         end else ex_i = 1'b0;
         tx_ready_i = r;
         @(negedge clk_i);
         if (r) idx++;
         cyc++;
      end
      ex_i = 1'b0;
      tx_ready_i = 1'b0;
      checkOutput("byte_count", 64'(idx), 64'(stop_at));
      if (stop_at == 26) begin
         checkOutput("end_valid", 64'(tx_valid_o), 64'd0);
         checkOutput("end_done", 64'(done_o), 64'd1);
         checkOutput("end_busy", 64'(busy_o), 64'd0);
      end
   endtask

   initial begin
      rst_i = 1'b1; ex_i = 1'b0; cause_i = '0; cycle_i = '0; instret_i = '0; tx_ready_i = 1'b0;
      doReset();

      $display("[TB] basic packet");
      applyStimulus(64'd2000, 64'd1000, 64'd8, 1'b0, 26);

      $display("[TB] ECALL after DONE is ignored");
      @(negedge clk_i);
      ex_i = 1'b1; cause_i = 64'd8;
      @(negedge clk_i);
      ex_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checkOutput("done_ignore_valid", 64'(tx_valid_o), 64'd0);
      checkOutput("done_ignore_done", 64'(done_o), 64'd1);

      $display("[TB] zero cycle count");
      doReset();
      applyStimulus(64'd0, 64'd5, 64'hb, 1'b0, 26);

      $display("[TB] non-ECALL cause ignored");
      doReset();
      @(negedge clk_i);
      ex_i = 1'b1; cause_i = 64'd2; cycle_i = 64'd777; instret_i = 64'd333;
      @(negedge clk_i);
      ex_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checkOutput("nonecall_busy", 64'(busy_o), 64'd0);
      checkOutput("nonecall_valid", 64'(tx_valid_o), 64'd0);
      ex_i = 1'b1; cause_i = 64'h108;
      @(negedge clk_i);
      ex_i = 1'b0;
      checkOutput("wide_cause_busy", 64'(busy_o), 64'd0);
      applyStimulus(64'd4000, 64'd2500, 64'd9, 1'b0, 26);

      $display("[TB] random backpressure");
      doReset();
      applyStimulus(64'd2000, 64'd1000, 64'd8, 1'b1, 26);

      $display("[TB] 74-bit dividend");
      doReset();
      applyStimulus(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd8, 1'b0, 26);

      $display("[TB] reset mid-packet");
      doReset();
      applyStimulus(64'd2000, 64'd1000, 64'd9, 1'b0, 12);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      checkOutput("abort_valid", 64'(tx_valid_o), 64'd0);
      checkOutput("abort_data", 64'(tx_data_o), 64'd0);
      checkOutput("abort_busy", 64'(busy_o), 64'd0);
      checkOutput("abort_done", 64'(done_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("abort_idle_valid", 64'(tx_valid_o), 64'd0);
      applyStimulus(64'd300, 64'd300, 64'd8, 1'b0, 26);

      $display("[TB] random packets");
      for (int t = 0; t < 4; t++) begin
         logic [63:0] c;
         logic [63:0] i;
         logic [63:0] k;
         c = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 60);
         i = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 40);
         case ($urandom_range(0, 2))
            0: k = 64'd8;
            1: k = 64'd9;
            default: k = 64'hb;
         endcase
         doReset();
         applyStimulus(c, i, k, 1'b1, 26);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
